ddr_deserializer: RTL and testbench

Parametrised double-data-rate input deserializer. It samples a DATA_WIDTH-bit bus on both clock edges, packs PAIRS rise/fall sample pairs into one word, and delivers words on a valid/ready stream through a 2-entry output buffer. It sits directly behind DDR pads, for example on a source-synchronous ADC or link input, and feeds the regular single-edge stream fabric.

---
 rtl/ddr_deserializer.sv | 132 +++++++++++++
 tb/tb_ddr_deserializer.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_deserializer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ddr_deserializer: packs DDR rise/fall sample pairs into words and    |
// | streams them out through a 2-entry valid/ready buffer. Rev 1.0       |
// +----------------------------------------------------------------------+
module ddr_deserializer #(
  parameter int DATA_WIDTH = 1,
  parameter int PAIRS      = 2
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [DATA_WIDTH-1:0]           i_din,
  input  logic                            i_din_en,
  input  logic                            i_align,
  output logic [2*PAIRS*DATA_WIDTH-1:0]   o_dout,
  output logic                            o_dout_vld,
  input  logic                            i_dout_rd,
  output logic                            o_ovf,
  input  logic                            i_ovf_clr
);

  localparam int c_w     = 2 * PAIRS * DATA_WIDTH;
  localparam int c_cnt_w = (PAIRS > 1) ? $clog2(PAIRS) : 1;

  logic [DATA_WIDTH-1:0] r_rise;
  logic [DATA_WIDTH-1:0] r_fall;
  logic                  r_en;
  logic [c_cnt_w-1:0]    r_cnt;
  logic [c_w-1:0]        r_word;
  logic [c_w-1:0]        r_head;
  logic [c_w-1:0]        r_tail;
  logic                  r_vld0;
  logic                  r_vld1;
  logic                  r_ovf;

  logic [c_w-1:0]        w_word;
  logic                  w_last;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_drop;

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fall <= '0;
    end else begin
      r_fall <= i_din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rise <= '0;
      r_en   <= 1'b0;
    end else begin
      r_rise <= i_din;
      r_en   <= i_din_en;
    end
  end

  // w_word is the partial word with the pair being consumed merged in.
  always_comb begin
    w_word = r_word;
    w_word[int'(r_cnt)*2*DATA_WIDTH +: 2*DATA_WIDTH] = {r_fall, r_rise};
    w_last = (r_cnt == c_cnt_w'(PAIRS - 1));
    w_push = r_en && !i_align && w_last;
    w_pop  = r_vld0 && i_dout_rd;
    w_drop = w_push && r_vld1 && !w_pop;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_word <= '0;
    end else if (i_align) begin
      r_cnt  <= '0;
      r_word <= '0;
    end else if (r_en) begin
      if (w_last) begin
        r_cnt  <= '0;
        r_word <= '0;
      end else begin
        r_cnt  <= r_cnt + c_cnt_w'(1);
        r_word <= w_word;
      end
    end
  end

  // Head register drives the outputs directly; tail holds the second entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head <= '0;
      r_tail <= '0;
      r_vld0 <= 1'b0;
      r_vld1 <= 1'b0;
      r_ovf  <= 1'b0;
    end else begin
      if (w_pop) begin
        if (w_push) begin
          if (r_vld1) begin
            r_head <= r_tail;
            r_tail <= w_word;
          end else begin
            r_head <= w_word;
          end
        end else begin
          r_head <= r_tail;
          r_vld0 <= r_vld1;
          r_vld1 <= 1'b0;
        end
      end else if (w_push) begin
        if (!r_vld0) begin
          r_head <= w_word;
          r_vld0 <= 1'b1;
        end else if (!r_vld1) begin
          r_tail <= w_word;
          r_vld1 <= 1'b1;
        end
      end
      if (w_drop) begin
        r_ovf <= 1'b1;
      end else if (i_ovf_clr) begin
        r_ovf <= 1'b0;
      end
    end
  end

  assign o_dout     = r_head;
  assign o_dout_vld = r_vld0;
  assign o_ovf      = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_ddr_deserializer.sv
`default_nettype none
// Bench for ddr_deserializer (DATA_WIDTH=4, PAIRS=2): queue-based model plus
// directed vectors with literal expectations.
module tb_ddr_deserializer;

  localparam int DW = 4;
  localparam int NP = 2;
  localparam int W  = 2 * NP * DW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] din = '0;
  logic          din_en = 1'b0;
  logic          align = 1'b0;
  logic          dout_rd = 1'b0;
  logic          ovf_clr = 1'b0;
  logic [W-1:0]  dout;
  logic          dout_vld;
  logic          ovf;

  int n_chk = 0;
  int n_err = 0;

  ddr_deserializer #(.DATA_WIDTH(DW), .PAIRS(NP)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_din      (din),
    .i_din_en   (din_en),
    .i_align    (align),
    .o_dout     (dout),
    .o_dout_vld (dout_vld),
    .i_dout_rd  (dout_rd),
    .o_ovf      (ovf),
    .i_ovf_clr  (ovf_clr)
  );

  always #5 clk = ~clk;

  // Model: pairs accumulate in a list; full words go to a 2-deep queue.
  logic [DW-1:0]   m_rise = '0;
  logic [DW-1:0]   m_fall = '0;
  logic            m_en = 1'b0;
  logic            m_ovf = 1'b0;
  logic [2*DW-1:0] m_part[$];
  logic [W-1:0]    m_q[$];
  logic            m_pop, m_push, m_drop;
  logic [W-1:0]    m_word;

  always @(posedge clk or negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_rise = '0; m_fall = '0; m_en = 1'b0; m_ovf = 1'b0;
      m_part.delete(); m_q.delete();
    end else if (clk) begin
      m_pop  = (m_q.size() > 0) && dout_rd;
      m_push = 1'b0;
      m_word = '0;
      if (align) m_part.delete();
      else if (m_en) begin
        m_part.push_back({m_fall, m_rise});
        if (m_part.size() == NP) begin
          for (int i = 0; i < NP; i++) m_word[i*2*DW +: 2*DW] = m_part[i];
          m_push = 1'b1;
          m_part.delete();
        end
      end
      m_drop = m_push && (m_q.size() == 2) && !m_pop;
      if (m_pop) void'(m_q.pop_front());
      if (m_push && !m_drop) m_q.push_back(m_word);
      if (m_drop) m_ovf = 1'b1;
      else if (ovf_clr) m_ovf = 1'b0;
      m_rise = din;
      m_en   = din_en;
    end else begin
      m_fall = din;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (rst_n) begin
      chk("m_vld", dout_vld, m_q.size() > 0);
      if (m_q.size() > 0) chk("m_dout", dout, m_q[0]);
      chk("m_ovf", ovf, m_ovf);
    end
  end

  // One cycle, entered just after a negedge: rise+controls, then fall.
  task automatic cyc(input logic [DW-1:0] r, input logic [DW-1:0] f,
                     input logic en, input logic al, input logic rd, input logic clr);
    #1;
    din = r; din_en = en; align = al; dout_rd = rd; ovf_clr = clr;
    @(posedge clk);
    #1 din = f;
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_vld", dout_vld, 0);
    chk("rst_dout", dout, 0);
    chk("rst_ovf", ovf, 0);
    #2 rst_n = 1'b1;
    @(negedge clk);

    // Streaming with ready held high: one word per two cycles.
    cyc(4'h1, 4'h0, 1, 0, 1, 0);
    cyc(4'h1, 4'h1, 1, 0, 1, 0);
    cyc(4'h2, 4'h3, 1, 0, 1, 0);
    chk("t1_w0", dout, 16'h1101);
    chk("t1_v0", dout_vld, 1);
    cyc(4'h4, 4'h5, 1, 0, 1, 0);
    cyc(4'h6, 4'h7, 1, 0, 1, 0);
    chk("t1_w1", dout, 16'h5432);
    cyc(4'h8, 4'h9, 1, 0, 1, 0);
    cyc(4'h0, 4'h0, 0, 0, 1, 0);
    chk("t1_w2", dout, 16'h9876);
    cyc(4'h0, 4'h0, 0, 0, 1, 0);

    // Disabled pair leaves no gap.
    cyc(4'hA, 4'h5, 1, 0, 0, 0);
    cyc(4'hF, 4'hF, 0, 0, 0, 0);
    cyc(4'h3, 4'hC, 1, 0, 0, 0);
    cyc(4'h0, 4'h0, 0, 0, 0, 0);
    chk("t2_w", dout, 16'hC35A);
    cyc(4'h0, 4'h0, 0, 0, 1, 0);
    chk("t2_empty", dout_vld, 0);

    // align drops the partial word and the pair consumed with it.
    cyc(4'h1, 4'h2, 1, 0, 1, 0);
    cyc(4'h3, 4'h4, 1, 0, 1, 0);
    cyc(4'h5, 4'h6, 1, 1, 1, 0);
    cyc(4'h7, 4'h8, 1, 0, 0, 0);
    chk("t3_none", dout_vld, 0);
    cyc(4'h0, 4'h0, 0, 0, 0, 0);
    chk("t3_w", dout, 16'h8765);
    cyc(4'h0, 4'h0, 0, 0, 1, 0);

    // Overflow: third word dropped, then drain and clear.
    for (int k = 1; k <= 3; k++) begin
      cyc(4'(k), 4'(k), 1, 0, 0, 0);
      cyc(4'(k), 4'(k), 1, 0, 0, 0);
    end
    cyc(4'h0, 4'h0, 0, 0, 0, 0);
    chk("t4_ovf", ovf, 1);
    chk("t4_w1", dout, 16'h1111);
    cyc(4'h0, 4'h0, 0, 0, 1, 0);
    chk("t4_w2", dout, 16'h2222);
    cyc(4'h0, 4'h0, 0, 0, 1, 0);
    chk("t4_empty", dout_vld, 0);
    chk("t4_sticky", ovf, 1);
    cyc(4'h0, 4'h0, 0, 0, 0, 1);
    chk("t4_clr", ovf, 0);

    // Full buffer, push and pop on the same edge: no drop.
    for (int k = 4; k <= 6; k++) begin
      cyc(4'(k), 4'(k), 1, 0, 0, 0);
      cyc(4'(k), 4'(k), 1, 0, 0, 0);
    end
    cyc(4'h0, 4'h0, 0, 0, 1, 0);
    chk("t4_pp_ovf", ovf, 0);
    chk("t4_pp_w", dout, 16'h5555);
    cyc(4'h0, 4'h0, 0, 0, 1, 0);
    chk("t4_pp_w3", dout, 16'h6666);
    cyc(4'h0, 4'h0, 0, 0, 1, 0);

    // Drop and clear on the same edge: set wins.
    for (int k = 10; k <= 12; k++) begin
      cyc(4'(k), 4'(k), 1, 0, 0, 0);
      cyc(4'(k), 4'(k), 1, 0, 0, 0);
    end
    cyc(4'h0, 4'h0, 0, 0, 0, 1);
    chk("t4_setwins", ovf, 1);
    cyc(4'h0, 4'h0, 0, 0, 0, 1);
    cyc(4'h0, 4'h0, 0, 0, 1, 0);
    cyc(4'h0, 4'h0, 0, 0, 1, 0);

    // Reset mid-word with a word buffered.
    cyc(4'h7, 4'h7, 1, 0, 0, 0);
    cyc(4'h7, 4'h7, 1, 0, 0, 0);
    cyc(4'h9, 4'h9, 1, 0, 0, 0);
    cyc(4'h9, 4'h9, 1, 0, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("r1_vld", dout_vld, 0);
    chk("r1_dout", dout, 0);
    chk("r1_ovf", ovf, 0);
    #1 rst_n = 1'b1;
    din = 4'hA; din_en = 1'b1;
    @(posedge clk);
    #1 din = 4'hA;
    @(negedge clk);
    cyc(4'hB, 4'hB, 1, 0, 0, 0);
    cyc(4'h0, 4'h0, 0, 0, 0, 0);
    chk("r1_w", dout, 16'hBBAA);

    // Reset between posedge and negedge.
    #1 din = 4'hD; din_en = 1'b1;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("r2_vld", dout_vld, 0);
    chk("r2_dout", dout, 0);
    #1 rst_n = 1'b1;
    @(negedge clk);
    cyc(4'h1, 4'h2, 1, 0, 0, 0);
    cyc(4'h3, 4'h4, 1, 0, 0, 0);
    cyc(4'h0, 4'h0, 0, 0, 0, 0);
    chk("r2_w", dout, 16'h4321);
    cyc(4'h0, 4'h0, 0, 0, 1, 0);
    cyc(4'h0, 4'h0, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
